// File: rtl/vector_issue_unit.sv
// Scalar-side issue unit for the vector request/response interface.
// Credits are reserved for every result-producing instruction before it issues.
module vector_issue_unit #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_src1Data,
  input  logic        in_wantResp,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_bits_inst,
  output logic [31:0] req_bits_src1Data,
  input  logic        resp_valid,
  input  logic [31:0] resp_bits_data,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic        idle,
  output logic        err_unexpected
);

  localparam int unsigned IAW = $clog2(DEPTH);
  localparam int unsigned ICW = $clog2(DEPTH + 1);
  localparam int unsigned RAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned PW  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ICW-1:0] I_FULL = ICW'(DEPTH);
  localparam logic [PW-1:0]  P_MAX  = PW'(MAX_OUTSTANDING);
  localparam logic [RAW-1:0] R_LAST = RAW'(MAX_OUTSTANDING - 1);

  logic [31:0]      inst_mem_q [DEPTH];
  logic [31:0]      src_mem_q  [DEPTH];
  logic [DEPTH-1:0] want_q;
  logic [IAW-1:0]   iwr_q, ird_q;
  logic [ICW-1:0]   icnt_q, icnt_d;

  logic [31:0]      res_mem_q [MAX_OUTSTANDING];
  logic [RAW-1:0]   rwr_q, rrd_q;
  logic [PW-1:0]    rcnt_q, rcnt_d;
  logic [PW-1:0]    pending_q, pending_d;
  logic             err_q;

  logic ipush, ipop, head_want, rpush, wbpop, inflight_nz;

  assign head_want         = want_q[ird_q];
  assign in_ready          = (icnt_q != I_FULL);
  assign req_valid         = (icnt_q != '0) && (!head_want || (pending_q < P_MAX));
  assign req_bits_inst     = inst_mem_q[ird_q];
  assign req_bits_src1Data = src_mem_q[ird_q];
  assign ipush             = in_valid && in_ready;
  assign ipop              = req_valid && req_ready;

  // rcount never exceeds pending, so inflight > 0 reduces to pending > rcount.
  assign inflight_nz = (pending_q > rcnt_q);
  assign rpush       = resp_valid && inflight_nz;
  assign wb_valid    = (rcnt_q != '0);
  assign wb_data     = res_mem_q[rrd_q];
  assign wbpop       = wb_valid && wb_ready;

  assign idle           = (icnt_q == '0) && (pending_q == '0);
  assign err_unexpected = err_q;

  always_comb begin
    icnt_d = icnt_q;
    if (ipush && !ipop)      icnt_d = icnt_q + ICW'(1);
    else if (!ipush && ipop) icnt_d = icnt_q - ICW'(1);

    rcnt_d = rcnt_q;
    if (rpush && !wbpop)      rcnt_d = rcnt_q + PW'(1);
    else if (!rpush && wbpop) rcnt_d = rcnt_q - PW'(1);

    pending_d = pending_q;
    if ((ipop && head_want) && !wbpop)      pending_d = pending_q + PW'(1);
    else if (!(ipop && head_want) && wbpop) pending_d = pending_q - PW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        src_mem_q[i]  <= '0;
      end
      want_q <= '0;
      iwr_q  <= '0;
      ird_q  <= '0;
      icnt_q <= '0;
    end else begin
      if (ipush) begin
        inst_mem_q[iwr_q] <= in_inst;
        src_mem_q[iwr_q]  <= in_src1Data;
        want_q[iwr_q]     <= in_wantResp;
        iwr_q             <= iwr_q + IAW'(1);
      end
      if (ipop) ird_q <= ird_q + IAW'(1);
      icnt_q <= icnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) res_mem_q[i] <= '0;
      rwr_q     <= '0;
      rrd_q     <= '0;
      rcnt_q    <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (rpush) begin
        res_mem_q[rwr_q] <= resp_bits_data;
        rwr_q            <= (rwr_q == R_LAST) ? '0 : rwr_q + RAW'(1);
      end
      if (wbpop) rrd_q <= (rrd_q == R_LAST) ? '0 : rrd_q + RAW'(1);
      rcnt_q    <= rcnt_d;
      pending_q <= pending_d;
      if (resp_valid && !inflight_nz) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_issue_unit.sv
// Bench for vector_issue_unit: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vector_issue_unit;

  localparam int DEPTH = 4;
  localparam int MAXO  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_wantResp, req_ready, resp_valid, wb_ready;
  logic [31:0] in_inst, in_src1Data, resp_bits_data;
  logic        in_ready, req_valid, wb_valid, idle, err_unexpected;
  logic [31:0] req_bits_inst, req_bits_src1Data, wb_data;

  vector_issue_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_src1Data(in_src1Data), .in_wantResp(in_wantResp),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_bits_inst(req_bits_inst), .req_bits_src1Data(req_bits_src1Data),
    .resp_valid(resp_valid), .resp_bits_data(resp_bits_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .idle(idle), .err_unexpected(err_unexpected)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: instruction queue, result queue, outstanding-result count.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] src;
    logic        want;
  } ent_t;

  ent_t        iq[$];
  logic [31:0] rq[$];
  int          pending = 0;
  bit          err_m = 1'b0;

  function automatic bit m_req_valid();
    return (iq.size() > 0) && (!iq[0].want || pending < MAXO);
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      iq.delete();
      rq.delete();
      pending = 0;
      err_m   = 1'b0;
    end else begin
      bit push, pop, wbf, rpush, bad;
      ent_t e;
      push  = in_valid && (iq.size() < DEPTH);
      pop   = m_req_valid() && req_ready;
      wbf   = (rq.size() > 0) && wb_ready;
      rpush = resp_valid && ((pending - rq.size()) > 0);
      bad   = resp_valid && ((pending - rq.size()) == 0);
      if (pop) begin
        if (iq[0].want) pending++;
        void'(iq.pop_front());
      end
      if (push) begin
        e.inst = in_inst; e.src = in_src1Data; e.want = in_wantResp;
        iq.push_back(e);
      end
      if (wbf) begin
        void'(rq.pop_front());
        pending--;
      end
      if (rpush) rq.push_back(resp_bits_data);
      if (bad) err_m = 1'b1;
    end
  end

  always @(negedge clock) begin
    chk("in_ready", {31'd0, in_ready}, {31'd0, iq.size() < DEPTH});
    chk("req_valid", {31'd0, req_valid}, {31'd0, m_req_valid()});
    if (m_req_valid()) begin
      chk("req_inst", req_bits_inst, iq[0].inst);
      chk("req_src1", req_bits_src1Data, iq[0].src);
    end
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, rq.size() > 0});
    if (rq.size() > 0) chk("wb_data", wb_data, rq[0]);
    chk("idle", {31'd0, idle}, {31'd0, (iq.size() == 0) && (pending == 0)});
    chk("err", {31'd0, err_unexpected}, {31'd0, err_m});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] inst, input logic [31:0] src, input logic want);
    in_valid = v; in_inst = inst; in_src1Data = src; in_wantResp = want;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_req_valid"}, {31'd0, req_valid}, 32'd0);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, idle}, 32'd1);
    chk({tag, "_req_inst"}, req_bits_inst, 32'd0);
    chk({tag, "_req_src1"}, req_bits_src1Data, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_err"}, {31'd0, err_unexpected}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    drive_in(1'b0, '0, '0, 1'b0);
    req_ready = 1'b0; resp_valid = 1'b0; resp_bits_data = '0; wb_ready = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b1;
    tick();

    // Three non-result instructions issued back to back
    req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, 32'hA000_0000 + i, 32'h5000_0000 + i, 1'b0);
      tick();
      chk("t1_req_valid", {31'd0, req_valid}, 32'd1);
      chk("t1_req_inst", req_bits_inst, 32'hA000_0000 + i);
      chk("t1_req_src1", req_bits_src1Data, 32'h5000_0000 + i);
    end
    drive_in(1'b0, '0, '0, 1'b0);
    chk("t1_busy", {31'd0, idle}, 32'd0);
    tick();
    chk("t1_idle", {31'd0, idle}, 32'd1);

    // Fill the FIFO while blocked, then drain
    req_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_in(1'b1, 32'hB000_0000 + i, 32'h6000_0000 + i, 1'b0);
      tick();
    end
    chk("t2_full", {31'd0, in_ready}, 32'd0);
    chk("t2_head", req_bits_inst, 32'hB000_0000);
    drive_in(1'b1, 32'hB000_00FF, 32'h6000_00FF, 1'b0);
    tick();
    chk("t2_stable", req_bits_inst, 32'hB000_0000);
    req_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_drain", req_bits_inst, 32'hB000_0000 + i);
      tick();
      drive_in(1'b0, '0, '0, 1'b0);
    end
    chk("t2_empty", {31'd0, req_valid}, 32'd0);

    // Credit limit on result-producing instructions
    for (int i = 0; i < 5; i++) begin
      drive_in(1'b1, 32'hC000_0000 + i, 32'h7000_0000 + i, 1'b1);
      tick();
    end
    drive_in(1'b0, '0, '0, 1'b0);
    chk("t3_blocked", {31'd0, req_valid}, 32'd0);
    chk("t3_head", req_bits_inst, 32'hC000_0004);
    tick();
    chk("t3_still_blocked", {31'd0, req_valid}, 32'd0);
    resp_valid = 1'b1; resp_bits_data = 32'hDEADBEEF;
    tick();
    resp_valid = 1'b0;
    chk("t3_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t3_wb_data", wb_data, 32'hDEADBEEF);
    chk("t3_no_issue", {31'd0, req_valid}, 32'd0);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("t3_issue", {31'd0, req_valid}, 32'd1);
    chk("t3_issue_inst", req_bits_inst, 32'hC000_0004);
    tick();
    chk("t3_gone", {31'd0, req_valid}, 32'd0);

    // Results held without writeback, last one overlaps the first pop
    for (int i = 1; i <= 3; i++) begin
      resp_valid = 1'b1; resp_bits_data = i;
      tick();
    end
    resp_bits_data = 32'd4; wb_ready = 1'b1;
    chk("t4_wb1", wb_data, 32'd1);
    tick();
    resp_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      chk("t4_wb_order", wb_data, i);
      tick();
    end
    wb_ready = 1'b0;
    chk("t4_wb_empty", {31'd0, wb_valid}, 32'd0);
    chk("t4_idle", {31'd0, idle}, 32'd1);

    // Unexpected response
    chk("t5_err_before", {31'd0, err_unexpected}, 32'd0);
    resp_valid = 1'b1; resp_bits_data = 32'h12345678;
    tick();
    resp_valid = 1'b0;
    chk("t5_err", {31'd0, err_unexpected}, 32'd1);
    chk("t5_no_wb", {31'd0, wb_valid}, 32'd0);
    tick(); tick();
    chk("t5_err_sticky", {31'd0, err_unexpected}, 32'd1);

    // Asynchronous reset with queued and outstanding work
    req_ready = 1'b1;
    drive_in(1'b1, 32'hD000_0000, 32'h8000_0000, 1'b1);
    tick();
    drive_in(1'b1, 32'hD000_0001, 32'h8000_0001, 1'b0);
    tick();
    req_ready = 1'b0;
    drive_in(1'b1, 32'hD000_0002, 32'h8000_0002, 1'b0);
    tick();
    drive_in(1'b0, '0, '0, 1'b0);
    chk("t6_busy", {31'd0, idle}, 32'd0);
    chk("t6_head", req_bits_inst, 32'hD000_0001);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    tick();
    reset = 1'b1;
    req_ready = 1'b1; wb_ready = 1'b1;
    tick(); tick();
    chk("t6_no_req", {31'd0, req_valid}, 32'd0);
    chk("t6_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("t6_idle", {31'd0, idle}, 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
